// File: rtl/div_unit.sv
// Multi-cycle restoring divider for DIV/DIVU: one quotient bit per clock,
// sign correction on the final edge, registered {remainder, quotient} result.
module div_unit #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  input  logic                  start_i,
  input  logic                  annul_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o
);

  localparam int unsigned RES_W = 2 * DATA_W;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W);

  typedef enum logic [1:0] {
    DivFree,
    DivByZero,
    DivOn,
    DivEnd
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   rem_q, rem_d;
  logic [DATA_W-1:0]   quo_q, quo_d;
  logic [DATA_W-1:0]   dvs_q, dvs_d;
  logic                sgn_q, sgn_d;
  logic                s1_q, s1_d;
  logic                s2_q, s2_d;
  logic [RES_W-1:0]    result_q, result_d;
  logic                ready_q, ready_d;

  logic [DATA_W:0]     upper_c;
  logic [DATA_W:0]     diff_c;
  logic                op1_neg_c;
  logic                op2_neg_c;
  logic [DATA_W-1:0]   quo_fix_c;
  logic [DATA_W-1:0]   rem_fix_c;

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= DivFree;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      sgn_q    <= 1'b0;
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      result_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      sgn_q    <= sgn_d;
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      result_q <= result_d;
      ready_q  <= ready_d;
    end
  end

  // Next-state, iteration step and output staging
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    sgn_d    = sgn_q;
    s1_d     = s1_q;
    s2_d     = s2_q;
    result_d = result_q;
    ready_d  = ready_q;

    // Trial subtraction on the 33-bit shifted partial remainder
    upper_c   = {rem_q, quo_q[DATA_W-1]};
    diff_c    = upper_c - {1'b0, dvs_q};
    op1_neg_c = signed_div_i & opdata1_i[DATA_W-1];
    op2_neg_c = signed_div_i & opdata2_i[DATA_W-1];
    quo_fix_c = (sgn_q && (s1_q ^ s2_q)) ? (DATA_W'(0) - quo_q) : quo_q;
    rem_fix_c = (sgn_q && s1_q) ? (DATA_W'(0) - rem_q) : rem_q;

    unique case (state_q)
      DivFree: begin
        ready_d  = 1'b0;
        result_d = '0;
        if (start_i && !annul_i) begin
          if (opdata2_i == '0) begin
            state_d = DivByZero;
          end else begin
            state_d = DivOn;
            cnt_d   = '0;
            rem_d   = '0;
            quo_d   = op1_neg_c ? (DATA_W'(0) - opdata1_i) : opdata1_i;
            dvs_d   = op2_neg_c ? (DATA_W'(0) - opdata2_i) : opdata2_i;
            sgn_d   = signed_div_i;
            s1_d    = opdata1_i[DATA_W-1];
            s2_d    = opdata2_i[DATA_W-1];
          end
        end
      end
      DivByZero: begin
        result_d = '0;
        if (annul_i) begin
          state_d = DivFree;
          ready_d = 1'b0;
        end else begin
          state_d = DivEnd;
          ready_d = 1'b1;
        end
      end
      DivOn: begin
        if (annul_i) begin
          state_d  = DivFree;
          ready_d  = 1'b0;
          result_d = '0;
        end else if (cnt_q == LAST_CNT) begin
          state_d  = DivEnd;
          ready_d  = 1'b1;
          result_d = {rem_fix_c, quo_fix_c};
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (!diff_c[DATA_W]) begin
            rem_d = diff_c[DATA_W-1:0];
            quo_d = {quo_q[DATA_W-2:0], 1'b1};
          end else begin
            rem_d = upper_c[DATA_W-1:0];
            quo_d = {quo_q[DATA_W-2:0], 1'b0};
          end
        end
      end
      DivEnd: begin
        if (!start_i) begin
          state_d  = DivFree;
          ready_d  = 1'b0;
          result_d = '0;
        end
      end
      default: state_d = DivFree;
    endcase
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: directed corner cases plus random divides
// checked against a plain-arithmetic reference model.
module tb_div_unit;

  logic        clk;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  int total = 0;
  int bad   = 0;
  logic [63:0] exp_q[$];

  div_unit #(.DATA_W(32), .CNT_W(6)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: truncating division, remainder takes the dividend's sign
  function automatic logic [63:0] model(input bit sg, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (sg) begin
      sa = $signed(a);
      sb = $signed(b);
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  // Monitor: compare on each rising ready_o
  initial begin
    logic rdy_prev;
    logic [63:0] e;
    rdy_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        rdy_prev = 1'b0;
      end else begin
        if (ready_o && !rdy_prev) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_ready: got result=%h expected no response", result_o);
          end else begin
            e = exp_q.pop_front();
            chk("result", result_o, e);
          end
        end
        rdy_prev = ready_o;
      end
    end
  end

  // One request; annul_at/chg_at are counter values (-1 = unused)
  task automatic do_div(input bit sg, input logic [31:0] a, input logic [31:0] b,
                        input int annul_at, input int chg_at);
    logic [63:0] e;
    int n;
    bit seen;
    e = model(sg, a, b);
    n = 0;
    seen = 1'b0;
    @(negedge clk);
    signed_div_i = sg;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    annul_i      = 1'b0;
    if (annul_at < 0) exp_q.push_back(e);
    while (n < 60) begin
      n++;
      @(posedge clk);
      @(negedge clk);
      if (ready_o) begin
        seen = 1'b1;
        break;
      end
      if (n == chg_at + 1) begin
        opdata1_i = $urandom;
        opdata2_i = $urandom;
        signed_div_i = ~sg;
      end
      if (annul_at >= 0 && n == annul_at + 1) begin
        annul_i = 1'b1;
        start_i = 1'b0;
      end
      if (annul_at >= 0 && n == annul_at + 2) annul_i = 1'b0;
    end
    if (annul_at >= 0) begin
      chk("annul_no_ready", 64'(seen), 64'd0);
      chk("annul_result", result_o, 64'd0);
    end else begin
      chk("latency", 64'(n), (b == 32'd0) ? 64'd2 : 64'd34);
      @(posedge clk);
      @(negedge clk);
      chk("hold_ready", 64'(ready_o), 64'd1);
      chk("hold_result", result_o, e);
      start_i = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("drop_ready", 64'(ready_o), 64'd0);
      chk("drop_result", result_o, 64'd0);
    end
    start_i = 1'b0;
    annul_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, b;
    bit sg;
    rst          = 1'b1;
    signed_div_i = 1'b0;
    opdata1_i    = '0;
    opdata2_i    = '0;
    start_i      = 1'b0;
    annul_i      = 1'b0;
    #1;
    chk("reset_ready", 64'(ready_o), 64'd0);
    chk("reset_result", result_o, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    do_div(1'b0, 32'd100, 32'd7, -1, -1);
    do_div(1'b1, 32'hFFFF_FFF9, 32'd2, -1, -1);
    do_div(1'b0, 32'hFFFF_FFF9, 32'd2, -1, -1);
    do_div(1'b1, 32'd1234, 32'd0, -1, -1);
    do_div(1'b0, 32'd55555, 32'd777, 10, -1);
    do_div(1'b0, 32'd9, 32'd3, -1, -1);

    // Asynchronous reset in the middle of an iteration run
    @(negedge clk);
    signed_div_i = 1'b0;
    opdata1_i    = 32'd1000;
    opdata2_i    = 32'd3;
    start_i      = 1'b1;
    repeat (8) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_ready", 64'(ready_o), 64'd0);
    chk("async_rst_result", result_o, 64'd0);
    start_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, -1, -1);
    do_div(1'b1, 32'hFFFF_CFC7, 32'd67, -1, 5);
    do_div(1'b0, 32'hDEAD_BEEF, 32'h0000_1234, -1, 5);

    for (int i = 0; i < 30; i++) begin
      sg = 1'($urandom_range(0, 1));
      a  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : 32'($urandom);
      case ($urandom_range(0, 5))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 16));
        2:       b = 32'hFFFF_FFFF;
        default: b = 32'($urandom);
      endcase
      do_div(sg, a, b, ($urandom_range(0, 9) == 0 && b != 32'd0) ? int'($urandom_range(0, 31)) : -1, -1);
    end

    repeat (3) @(negedge clk);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
